// File: rtl/axi_sram_if.sv
// AXI-lite style bus between a master and the single-port SRAM slave.
// Signal names follow the slave's published port list.
interface axi_sram_if;
  logic [63:0] AW_ADDR;
  logic        AW_VALID;
  logic        AW_READY;
  logic [63:0] W_DATA;
  logic [7:0]  W_STRB;
  logic        W_VALID;
  logic        W_READY;
  logic        B_VALID;
  logic        B_READY;
  logic [63:0] AR_ADDR;
  logic        AR_VALID;
  logic        AR_READY;
  logic [63:0] R_DATA;
  logic        R_VALID;
  logic        R_READY;

  modport slave (
    input  AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY,
           AR_ADDR, AR_VALID, R_READY,
    output AW_READY, W_READY, B_VALID, AR_READY, R_DATA, R_VALID
  );

  modport master (
    output AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY,
           AR_ADDR, AR_VALID, R_READY,
    input  AW_READY, W_READY, B_VALID, AR_READY, R_DATA, R_VALID
  );
endinterface

// File: rtl/axi_sram_slave.sv
// 64-bit SRAM slave with independent write (AW/W/B) and read (AR/R) channels.
// Every READY/VALID/R_DATA output comes straight from a flop.
module axi_sram_slave #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 2,
  parameter logic [63:0] BASE   = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       rst,
  axi_sram_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  logic [63:0] mem_q [DEPTH];

  function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] addr);
    return IDX_W'((addr - BASE) >> 3);
  endfunction

  // write channel state
  logic [0:0]       w_state_q, w_state_d;
  logic             aw_held_q, aw_held_d;
  logic             w_held_q, w_held_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic [63:0]      w_data_q, w_data_d;
  logic [7:0]       w_strb_q, w_strb_d;
  logic             aw_ready_q, aw_ready_d;
  logic             w_ready_q, w_ready_d;
  logic             b_valid_q, b_valid_d;
  logic             commit_c;

  // read channel state
  logic [1:0]       r_state_q, r_state_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      r_data_q, r_data_d;
  logic             ar_ready_q, ar_ready_d;
  logic             r_valid_q, r_valid_d;

  // AW and W may arrive in any order; commit fires once both are held
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    commit_c  = 1'b0;
    if (w_state_q == W_IDLE) begin
      if (bus.AW_VALID && aw_ready_q) begin
        aw_held_d = 1'b1;
        aw_idx_d  = word_idx(bus.AW_ADDR);
      end
      if (bus.W_VALID && w_ready_q) begin
        w_held_d = 1'b1;
        w_data_d = bus.W_DATA;
        w_strb_d = bus.W_STRB;
      end
      if (aw_held_d && w_held_d) begin
        commit_c  = 1'b1;
        w_state_d = W_RESP;
      end
    end else if (b_valid_q && bus.B_READY) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      w_state_d = W_IDLE;
    end
    aw_ready_d = (w_state_d == W_IDLE) && !aw_held_d;
    w_ready_d  = (w_state_d == W_IDLE) && !w_held_d;
    b_valid_d  = (w_state_d == W_RESP);
  end

  // data is latched from the pre-write array, so a same-edge write to the word is not seen
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    cnt_d     = cnt_q;
    r_data_d  = r_data_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.AR_VALID && ar_ready_q) begin
          r_idx_d = word_idx(bus.AR_ADDR);
          cnt_d   = CNT_W'(RD_LAT - 1);
          if (RD_LAT == 1) begin
            r_data_d  = mem_q[r_idx_d];
            r_state_d = R_RESP;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          r_data_d  = mem_q[r_idx_q];
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (r_valid_q && bus.R_READY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    ar_ready_d = (r_state_d == R_IDLE);
    r_valid_d  = (r_state_d == R_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      r_state_q  <= R_IDLE;
      r_idx_q    <= '0;
      cnt_q      <= '0;
      r_data_q   <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      r_state_q  <= r_state_d;
      r_idx_q    <= r_idx_d;
      cnt_q      <= cnt_d;
      r_data_q   <= r_data_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
    end
  end

  // storage survives reset; a commit coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (commit_c && !rst) begin
      for (int i = 0; i < 8; i++) begin
        if (w_strb_d[i]) mem_q[aw_idx_d][8*i +: 8] <= w_data_d[8*i +: 8];
      end
    end
  end

  assign bus.AW_READY = aw_ready_q;
  assign bus.W_READY  = w_ready_q;
  assign bus.B_VALID  = b_valid_q;
  assign bus.AR_READY = ar_ready_q;
  assign bus.R_VALID  = r_valid_q;
  assign bus.R_DATA   = r_data_q;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: RD_LAT=2 and RD_LAT=1 instances, read data
// checked by per-instance scoreboard monitors, timing/handshake checked inline.
module tb_axi_sram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_sram_if bus0 ();
  axi_sram_if bus1 ();

  axi_sram_slave #(.DEPTH(256), .RD_LAT(2), .BASE(64'h8000_0000)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  axi_sram_slave #(.DEPTH(256), .RD_LAT(1), .BASE(64'h8000_0000)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  virtual axi_sram_if v0;
  virtual axi_sram_if v1;

  int n_tot  = 0;
  int n_pass = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // read-data scoreboards: compare on each R handshake
  always @(negedge clk) begin
    if (!rst && bus0.R_VALID && bus0.R_READY) begin
      if (q0.size() == 0) begin
        n_tot++;
        $display("FAIL r_unexpected0: got %h with no expected entry", bus0.R_DATA);
      end else check("r_data0", bus0.R_DATA, q0.pop_front());
    end
    if (!rst && bus1.R_VALID && bus1.R_READY) begin
      if (q1.size() == 0) begin
        n_tot++;
        $display("FAIL r_unexpected1: got %h with no expected entry", bus1.R_DATA);
      end else check("r_data1", bus1.R_DATA, q1.pop_front());
    end
  end

  task automatic send_aw_w(input int id, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] s);
    virtual axi_sram_if vif;
    logic aw_f, w_f;
    int n;
    if (id == 0) vif = v0; else vif = v1;
    n = 0;
    vif.AW_ADDR = a; vif.AW_VALID = 1'b1;
    vif.W_DATA = d; vif.W_STRB = s; vif.W_VALID = 1'b1;
    while ((vif.AW_VALID || vif.W_VALID) && n < 20) begin
      aw_f = vif.AW_VALID && vif.AW_READY;
      w_f  = vif.W_VALID && vif.W_READY;
      tick();
      n++;
      if (aw_f) vif.AW_VALID = 1'b0;
      if (w_f)  vif.W_VALID  = 1'b0;
    end
    check("aw_w_accepted", 64'({vif.AW_VALID, vif.W_VALID}), 64'd0);
    vif.AW_VALID = 1'b0; vif.W_VALID = 1'b0;
    check("b_valid_after_commit", 64'(vif.B_VALID), 64'd1);
  endtask

  task automatic b_resp(input int id, input int stall);
    virtual axi_sram_if vif;
    int n;
    if (id == 0) vif = v0; else vif = v1;
    for (int i = 0; i < stall; i++) begin
      check("b_stall", 64'({vif.B_VALID, vif.AW_READY, vif.W_READY}), 64'(3'b100));
      tick();
    end
    vif.B_READY = 1'b1;
    n = 0;
    while (!vif.B_VALID && n < 20) begin tick(); n++; end
    check("b_valid", 64'(vif.B_VALID), 64'd1);
    tick();
    vif.B_READY = 1'b0;
    check("b_done", 64'({vif.B_VALID, vif.AW_READY, vif.W_READY}), 64'(3'b011));
  endtask

  task automatic wr(input int id, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    send_aw_w(id, a, d, s);
    b_resp(id, 0);
  endtask

  task automatic rd(input int id, input logic [63:0] a, input logic [63:0] e, input int stall);
    virtual axi_sram_if vif;
    int n, edges, lat;
    if (id == 0) begin vif = v0; lat = 2; end else begin vif = v1; lat = 1; end
    n = 0;
    vif.AR_ADDR = a; vif.AR_VALID = 1'b1;
    while (!vif.AR_READY && n < 20) begin tick(); n++; end
    check("ar_ready", 64'(vif.AR_READY), 64'd1);
    tick();
    vif.AR_VALID = 1'b0;
    if (id == 0) q0.push_back(e); else q1.push_back(e);
    // edges counts clock edges from the AR handshake to the first edge sampling R_VALID=1
    edges = 1;
    while (!vif.R_VALID && edges < 20) begin tick(); edges++; end
    check("rd_latency", 64'(edges), 64'(lat));
    for (int i = 0; i < stall; i++) begin
      check("r_stall", 64'({vif.R_VALID, vif.AR_READY}), 64'(2'b10));
      check("r_data_stable", vif.R_DATA, e);
      tick();
    end
    vif.R_READY = 1'b1;
    tick();
    vif.R_READY = 1'b0;
    check("r_done", 64'({vif.R_VALID, vif.AR_READY}), 64'(2'b01));
  endtask

  task automatic idle_bus(input int id);
    virtual axi_sram_if vif;
    if (id == 0) vif = v0; else vif = v1;
    vif.AW_ADDR = '0; vif.AW_VALID = 1'b0; vif.W_DATA = '0; vif.W_STRB = '0;
    vif.W_VALID = 1'b0; vif.B_READY = 1'b0; vif.AR_ADDR = '0; vif.AR_VALID = 1'b0;
    vif.R_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    v0 = bus0;
    v1 = bus1;
    idle_bus(0);
    idle_bus(1);
    rst = 1'b1;
    repeat (3) tick();

    // reset state and first cycle after release
    check("rst_outs0", 64'({bus0.AW_READY, bus0.W_READY, bus0.AR_READY, bus0.B_VALID, bus0.R_VALID}), 64'd0);
    check("rst_rdata0", bus0.R_DATA, 64'd0);
    check("rst_outs1", 64'({bus1.AW_READY, bus1.W_READY, bus1.AR_READY, bus1.B_VALID, bus1.R_VALID}), 64'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst0", 64'({bus0.AW_READY, bus0.W_READY, bus0.AR_READY}), 64'(3'b111));
    check("ready_after_rst1", 64'({bus1.AW_READY, bus1.W_READY, bus1.AR_READY}), 64'(3'b111));

    // AW+W same cycle, read back
    wr(0, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    rd(0, 64'h8000_0010, 64'h1122_3344_5566_7788, 0);

    // W three cycles ahead of AW, single-byte strobe
    wr(0, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    bus0.W_DATA = 64'h5555_5555_5555_55AA; bus0.W_STRB = 8'h01; bus0.W_VALID = 1'b1;
    check("w_ready_first", 64'(bus0.W_READY), 64'd1);
    tick();
    bus0.W_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("w_held_ready", 64'({bus0.W_READY, bus0.AW_READY}), 64'(2'b01));
      if (i < 2) tick();
    end
    bus0.AW_ADDR = 64'h8000_0020; bus0.AW_VALID = 1'b1;
    tick();
    bus0.AW_VALID = 1'b0;
    check("b_after_late_aw", 64'(bus0.B_VALID), 64'd1);
    b_resp(0, 0);
    rd(0, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFAA, 0);

    // B back-pressure with a second AW waiting
    send_aw_w(0, 64'h8000_0030, 64'hCAFE_F00D_1234_5678, 8'hFF);
    bus0.AW_ADDR = 64'h8000_0038; bus0.AW_VALID = 1'b1;
    b_resp(0, 5);
    send_aw_w(0, 64'h8000_0038, 64'h0F0E_0D0C_0B0A_0908, 8'hFF);
    b_resp(0, 0);
    rd(0, 64'h8000_0030, 64'hCAFE_F00D_1234_5678, 0);

    // R back-pressure, then RD_LAT=1 instance
    rd(0, 64'h8000_0038, 64'h0F0E_0D0C_0B0A_0908, 4);
    wr(1, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF);
    rd(1, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 0);

    // address wrap aliases word 0
    wr(0, 64'h8000_0800, 64'hA5A5_5A5A_C3C3_3C3C, 8'hFF);
    rd(0, 64'h8000_0000, 64'hA5A5_5A5A_C3C3_3C3C, 0);

    // same-edge write commit and read latch to one word returns old data
    wr(1, 64'h8000_0040, 64'h0000_0000_0000_01D0, 8'hFF);
    q1.push_back(64'h0000_0000_0000_01D0);
    bus1.AR_ADDR = 64'h8000_0040; bus1.AR_VALID = 1'b1;
    bus1.AW_ADDR = 64'h8000_0040; bus1.AW_VALID = 1'b1;
    bus1.W_DATA = 64'h0000_0000_0000_0E3E; bus1.W_STRB = 8'hFF; bus1.W_VALID = 1'b1;
    check("same_edge_ready", 64'({bus1.AW_READY, bus1.W_READY, bus1.AR_READY}), 64'(3'b111));
    tick();
    bus1.AR_VALID = 1'b0; bus1.AW_VALID = 1'b0; bus1.W_VALID = 1'b0;
    check("same_edge_valids", 64'({bus1.B_VALID, bus1.R_VALID}), 64'(2'b11));
    bus1.R_READY = 1'b1;
    tick();
    bus1.R_READY = 1'b0;
    b_resp(1, 0);
    rd(1, 64'h8000_0040, 64'h0000_0000_0000_0E3E, 0);

    // reset while write sits in W_RESP and read sits in R_WAIT
    send_aw_w(0, 64'h8000_0048, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    bus0.AR_ADDR = 64'h8000_0010; bus0.AR_VALID = 1'b1;
    tick();
    bus0.AR_VALID = 1'b0;
    check("in_r_wait", 64'({bus0.R_VALID, bus0.AR_READY, bus0.B_VALID}), 64'(3'b001));
    rst = 1'b1;
    tick();
    check("mid_rst_outs", 64'({bus0.AW_READY, bus0.W_READY, bus0.AR_READY, bus0.B_VALID, bus0.R_VALID}), 64'd0);
    check("mid_rst_rdata", bus0.R_DATA, 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_outs", 64'({bus0.AW_READY, bus0.W_READY, bus0.AR_READY, bus0.B_VALID, bus0.R_VALID}), 64'(5'b11100));
    tick();
    check("dropped_read", 64'(bus0.R_VALID), 64'd0);
    rd(0, 64'h8000_0010, 64'h1122_3344_5566_7788, 0);
    rd(0, 64'h8000_0048, 64'hDEAD_BEEF_0BAD_F00D, 0);
    rd(1, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 0);

    repeat (3) tick();
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 64-bit memory words (power of two).
REQ-002 SHALL have parameter RD_LAT, default 2, cycles from AR handshake to R_VALID (legal range 1..15).
REQ-003 SHALL have parameter BASE, default 64'h8000_0000, byte address mapped to word 0.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 AW_ADDR  in  64  write byte address.
REQ-007 AW_VALID  in  1 / AW_READY  out  1  write-address handshake.
REQ-008 W_DATA  in  64 / W_STRB  in  8  write data and per-byte enables.
REQ-009 W_VALID  in  1 / W_READY  out  1  write-data handshake.
REQ-010 B_VALID  out  1 / B_READY  in  1  write-response handshake.
REQ-011 AR_ADDR  in  64  read byte address.
REQ-012 AR_VALID  in  1 / AR_READY  out  1  read-address handshake.
REQ-013 R_DATA  out  64 / R_VALID  out  1 / R_READY  in  1  read-data handshake.

Function
REQ-014 Handshake on any channel SHALL be X_VALID & X_READY high at a rising edge.
REQ-015 Word index SHALL be ((addr - BASE) >> 3) truncated to log2(DEPTH) bits; out-of-range addresses wrap, no error response.
REQ-016 Write FSM states SHALL be W_IDLE and W_RESP.
REQ-017 In W_IDLE, AW_READY SHALL equal !aw_held and W_READY SHALL equal !w_held; AW and W are accepted in either order or the same cycle.
REQ-018 On the edge where both AW and W are held or handshaking, the write SHALL commit: byte i of the word updated only if W_STRB[i]=1; FSM goes to W_RESP.
REQ-019 In W_RESP, B_VALID SHALL be 1 and AW_READY and W_READY 0; on B handshake, the FSM SHALL clear both held flags and return to W_IDLE.
REQ-020 Read FSM states SHALL be R_IDLE, R_WAIT and R_RESP; AR_READY SHALL be 1 only in R_IDLE.
REQ-021 On AR handshake, the FSM SHALL capture the index and load counter = RD_LAT-1.
  - RD_LAT=1: go straight to R_RESP.
  - Otherwise: go to R_WAIT.
REQ-022 In R_WAIT, the counter SHALL decrement each cycle; at the edge where counter==1, R_DATA SHALL latch mem[index] and the FSM go to R_RESP.
REQ-023 R_VALID SHALL rise exactly RD_LAT cycles after the AR handshake edge.
REQ-024 In R_RESP, R_VALID SHALL be 1 and R_DATA held stable until the R handshake, then return to R_IDLE.
REQ-025 Read and write FSMs SHALL run independently and concurrently.
REQ-026 If a write commit and a read data latch to the same word occur on the same edge, R_DATA SHALL return the old (pre-write) word.
REQ-027 No combinational path SHALL exist from any input to any READY or VALID output.

Reset
REQ-028 While rst=1, at each edge:
  - AW_READY, W_READY, AR_READY, B_VALID, R_VALID and R_DATA SHALL be 0.
  - Both FSMs SHALL be in their idle states, with held flags and counter cleared.
REQ-029 Reset asserted mid-transaction SHALL drop the pending transaction with no commit; a write already committed stays.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 First cycle after rst deasserts: AW_READY=W_READY=AR_READY=1.

Verification
REQ-032 AW=0x8000_0010 and W=0x1122334455667788, STRB=0xFF in the same cycle -> B_VALID next cycle; then AR=0x8000_0010 -> R_VALID 2 cycles after handshake, R_DATA=0x1122334455667788.
REQ-033 W before AW (W at t, AW at t+3), STRB=0x01, data 0xAA over word 0xFFFF...FF -> W_READY=0 during t+1..t+3; read-back 0xFFFFFFFFFFFFFFAA.
REQ-034 B_READY=0 for 5 cycles -> B_VALID held, AW_READY=W_READY=0 throughout; a second AW is accepted only after B handshake.
REQ-035 R_READY=0 for 4 cycles -> R_VALID and R_DATA stable, AR_READY=0; with RD_LAT=1, R_VALID 1 cycle after AR handshake.
REQ-036 Address 0x8000_0000 + 8*DEPTH -> aliases word 0; same-edge write/read-latch to one word returns old data.
REQ-037 rst pulsed while in R_WAIT and W_RESP -> all VALIDs 0 next cycle, READYs 1 after release, prior committed data readable.
